mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single fixed-latency memory port.
// One transaction in flight; alternating priority on conflict.
module mem_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int MEM_LAT    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_req_valid,
   input  logic [ADDR_WIDTH-1:0] i_req_addr,
   output logic                  i_req_ready,
   output logic                  i_rsp_valid,
   output logic [DATA_WIDTH-1:0] i_rsp_data,
   input  logic                  d_req_valid,
   input  logic                  d_req_we,
   input  logic [2:0]            d_req_width,
   input  logic [ADDR_WIDTH-1:0] d_req_addr,
   input  logic [DATA_WIDTH-1:0] d_req_wdata,
   output logic                  d_req_ready,
   output logic                  d_rsp_valid,
   output logic [DATA_WIDTH-1:0] d_rsp_data,
   output logic                  mem_re,
   output logic                  mem_we,
   output logic [2:0]            mem_width,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  stall
);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

   localparam logic       OWNER_I    = 1'b0;
   localparam logic       OWNER_D    = 1'b1;
   localparam logic [2:0] FETCH_WIDTH = 3'b010;
   // The counter is reloaded on leaving ACCESS, so WAIT lasts exactly MEM_LAT cycles.
   localparam logic [3:0] LAT_RELOAD = 4'(MEM_LAT - 1);

   state_t     state_q;
   logic [3:0] cnt_q;
   logic       owner_q;
   logic       lastOwner_q;
   logic       we_q;
   logic       grantI;
   logic       grantD;

   // Grant decision: only in IDLE and never while reset is held.
   always_comb begin
      grantI = 1'b0;
      grantD = 1'b0;
      if (state_q == IDLE && !rst) begin
         if (i_req_valid && (!d_req_valid || lastOwner_q == OWNER_D)) begin
            grantI = 1'b1;
         end else if (d_req_valid) begin
            grantD = 1'b1;
         end
      end
   end

   assign i_req_ready = grantI;
   assign d_req_ready = grantD;
   assign stall       = (state_q != IDLE) || (i_req_valid && d_req_valid);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         owner_q     <= OWNER_I;
         lastOwner_q <= OWNER_D;
         we_q        <= 1'b0;
         mem_re      <= 1'b0;
         mem_we      <= 1'b0;
         mem_width   <= '0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         i_rsp_valid <= 1'b0;
         d_rsp_valid <= 1'b0;
         i_rsp_data  <= '0;
         d_rsp_data  <= '0;
      end else begin
         i_rsp_valid <= 1'b0;
         d_rsp_valid <= 1'b0;
         case (state_q)
            IDLE: begin
               if (grantI) begin
                  mem_addr    <= i_req_addr;
                  mem_wdata   <= '0;
                  mem_width   <= FETCH_WIDTH;
                  we_q        <= 1'b0;
                  owner_q     <= OWNER_I;
                  lastOwner_q <= OWNER_I;
                  mem_re      <= 1'b1;
                  state_q     <= ACCESS;
               end else if (grantD) begin
                  mem_addr    <= d_req_addr;
                  mem_wdata   <= d_req_wdata;
                  mem_width   <= d_req_width;
                  we_q        <= d_req_we;
                  owner_q     <= OWNER_D;
                  lastOwner_q <= OWNER_D;
                  mem_re      <= !d_req_we;
                  mem_we      <= d_req_we;
                  state_q     <= ACCESS;
               end
            end
            ACCESS: begin
               mem_re  <= 1'b0;
               mem_we  <= 1'b0;
               cnt_q   <= LAT_RELOAD;
               state_q <= WAIT;
            end
            WAIT: begin
               if (cnt_q == 4'd0) begin
                  state_q <= RESP;
                  if (owner_q == OWNER_D) begin
                     d_rsp_valid <= 1'b1;
                     if (!we_q) begin
                        d_rsp_data <= mem_rdata;
                     end
                  end else begin
                     i_rsp_valid <= 1'b1;
                     i_rsp_data  <= mem_rdata;
                  end
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            RESP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: one instance with MEM_LAT=1 and one with MEM_LAT=4
// sharing stimulus; the index s selects which instance is being checked.
module tb_mem_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        iReqValid = 1'b0;
   logic [31:0] iReqAddr = '0;
   logic        dReqValid = 1'b0;
   logic        dReqWe = 1'b0;
   logic [2:0]  dReqWidth = '0;
   logic [31:0] dReqAddr = '0;
   logic [31:0] dReqWdata = '0;
   logic [31:0] memRdata = '0;

   logic        iReady[2];
   logic        iRspValid[2];
   logic [31:0] iRspData[2];
   logic        dReady[2];
   logic        dRspValid[2];
   logic [31:0] dRspData[2];
   logic        memRe[2];
   logic        memWe[2];
   logic [2:0]  memWidth[2];
   logic [31:0] memAddr[2];
   logic [31:0] memWdata[2];
   logic        stall[2];

   int checks = 0;
   int failures = 0;
   int s = 0;

   mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LAT(1)) dutLat1 (
      .clk(clk), .rst(rst),
      .i_req_valid(iReqValid), .i_req_addr(iReqAddr), .i_req_ready(iReady[0]),
      .i_rsp_valid(iRspValid[0]), .i_rsp_data(iRspData[0]),
      .d_req_valid(dReqValid), .d_req_we(dReqWe), .d_req_width(dReqWidth),
      .d_req_addr(dReqAddr), .d_req_wdata(dReqWdata), .d_req_ready(dReady[0]),
      .d_rsp_valid(dRspValid[0]), .d_rsp_data(dRspData[0]),
      .mem_re(memRe[0]), .mem_we(memWe[0]), .mem_width(memWidth[0]),
      .mem_addr(memAddr[0]), .mem_wdata(memWdata[0]), .mem_rdata(memRdata),
      .stall(stall[0])
   );

   mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LAT(4)) dutLat4 (
      .clk(clk), .rst(rst),
      .i_req_valid(iReqValid), .i_req_addr(iReqAddr), .i_req_ready(iReady[1]),
      .i_rsp_valid(iRspValid[1]), .i_rsp_data(iRspData[1]),
      .d_req_valid(dReqValid), .d_req_we(dReqWe), .d_req_width(dReqWidth),
      .d_req_addr(dReqAddr), .d_req_wdata(dReqWdata), .d_req_ready(dReady[1]),
      .d_rsp_valid(dRspValid[1]), .d_rsp_data(dRspData[1]),
      .mem_re(memRe[1]), .mem_we(memWe[1]), .mem_width(memWidth[1]),
      .mem_addr(memAddr[1]), .mem_wdata(memWdata[1]), .mem_rdata(memRdata),
      .stall(stall[1])
   );

   typedef struct packed {
      logic iV;
      logic dV;
      logic dWe;
      logic expIReady;
      logic expDReady;
      logic expStall;
      logic expRe;
      logic expWe;
   } vec_t;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s (lat%0d): got %h expected %h at %0t", name, (s == 0) ? 1 : 4, act, exp, $time);
      end
   endtask

   // Leaves the bench at a falling edge with reset just released.
   task automatic applyReset();
      rst = 1'b1;
      iReqValid = 1'b0; iReqAddr = '0;
      dReqValid = 1'b0; dReqWe = 1'b0; dReqWidth = '0; dReqAddr = '0; dReqWdata = '0;
      memRdata = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Each vector: reset values, idle arbitration after reset, the ACCESS strobe, then async strobe drop.
   task automatic applyStimulus(input vec_t v);
      rst = 1'b1;
      iReqValid = v.iV; iReqAddr = 32'h20;
      dReqValid = v.dV; dReqWe = v.dWe; dReqAddr = 32'h24; dReqWidth = 3'b001; dReqWdata = 32'h55AA55AA;
      memRdata = '0;
      @(negedge clk); #1;
      checkOutput("rstIReady", iReady[s], 0);
      checkOutput("rstDReady", dReady[s], 0);
      checkOutput("rstMemRe", memRe[s], 0);
      checkOutput("rstMemWe", memWe[s], 0);
      checkOutput("rstRspValid", iRspValid[s] | dRspValid[s], 0);
      checkOutput("rstIRspData", iRspData[s], 0);
      checkOutput("rstDRspData", dRspData[s], 0);
      checkOutput("rstMemAddr", memAddr[s], 0);
      checkOutput("rstMemWdata", memWdata[s], 0);
      checkOutput("rstMemWidth", memWidth[s], 0);
      rst = 1'b0; #1;
      checkOutput("vecIReady", iReady[s], v.expIReady);
      checkOutput("vecDReady", dReady[s], v.expDReady);
      checkOutput("vecStall", stall[s], v.expStall);
      @(negedge clk); #1;
      checkOutput("vecMemRe", memRe[s], v.expRe);
      checkOutput("vecMemWe", memWe[s], v.expWe);
      rst = 1'b1; #1;
      checkOutput("rstDropRe", memRe[s], 0);
      checkOutput("rstDropWe", memWe[s], 0);
      iReqValid = 1'b0; dReqValid = 1'b0;
   endtask

   // Issues one data request, then scrambles the request inputs while it is in flight.
   task automatic runDataTxn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int lat,
                             output int strobeCnt, output int rspCnt);
      int waitCnt;
      waitCnt = 0; strobeCnt = 0; rspCnt = 0;
      dReqValid = 1'b1; dReqWe = we; dReqAddr = addr; dReqWdata = wdata; dReqWidth = 3'b010;
      memRdata = rdata;
      #1;
      while (!dReady[s] && waitCnt < 20) begin
         @(negedge clk); #1;
         waitCnt++;
      end
      checkOutput("dataGrant", dReady[s], 1);
      for (int k = 1; k <= lat + 3; k++) begin
         @(negedge clk);
         dReqValid = 1'b0; dReqAddr = ~addr; dReqWdata = ~wdata; dReqWe = ~we; dReqWidth = 3'b111;
         #1;
         if (memRe[s] || memWe[s]) begin
            strobeCnt++;
            checkOutput("strobeKind", memWe[s], we);
            checkOutput("strobeAddr", memAddr[s], addr);
            checkOutput("strobeWidth", memWidth[s], 3'b010);
            if (we) checkOutput("strobeWdata", memWdata[s], wdata);
         end
         if (dRspValid[s]) rspCnt++;
      end
   endtask

   // Transaction-level reference: a grant at cycle g gives a strobe at g+1 and a response at
   // g+2+lat carrying the read data driven one cycle earlier; the port is free again at g+3+lat.
   task automatic runRandom(input int lat, input int n);
      bit busy, ownD, tWe, lastD, iHs, dHs, wdataKnown;
      int g, k;
      logic [31:0] expI, expD, expAddr, expWdata, prevRdata;
      logic [2:0]  expWidth;
      logic eIReady, eDReady, eStall, eRe, eWe, eIV, eDV;
      busy = 0; ownD = 0; tWe = 0; lastD = 1; iHs = 0; dHs = 0; wdataKnown = 1;
      g = 0;
      expI = '0; expD = '0; expAddr = '0; expWdata = '0; expWidth = '0;
      applyReset();
      for (int c = 0; c < n; c++) begin
         if (iHs || !iReqValid) begin
            iReqValid = ($urandom_range(0, 2) != 0);
            iReqAddr = $urandom & 32'hFFFF_FFFC;
         end
         if (dHs || !dReqValid) begin
            dReqValid = ($urandom_range(0, 2) != 0);
            dReqWe = 1'($urandom_range(0, 1));
            dReqWidth = 3'($urandom_range(0, 7));
            dReqAddr = $urandom;
            dReqWdata = $urandom;
         end
         iHs = 0; dHs = 0;
         prevRdata = memRdata;
         memRdata = $urandom;
         #1;
         k = c - g;
         eIReady = !busy && iReqValid && (!dReqValid || lastD);
         eDReady = !busy && dReqValid && !eIReady;
         eStall = busy || (iReqValid && dReqValid);
         eRe = busy && k == 1 && !tWe;
         eWe = busy && k == 1 && tWe;
         eIV = 0; eDV = 0;
         if (busy && k == lat + 2) begin
            if (ownD) begin
               eDV = 1;
               if (!tWe) expD = prevRdata;
            end else begin
               eIV = 1;
               expI = prevRdata;
            end
         end
         checkOutput("rndIReady", iReady[s], eIReady);
         checkOutput("rndDReady", dReady[s], eDReady);
         checkOutput("rndStall", stall[s], eStall);
         checkOutput("rndMemRe", memRe[s], eRe);
         checkOutput("rndMemWe", memWe[s], eWe);
         checkOutput("rndIRspValid", iRspValid[s], eIV);
         checkOutput("rndDRspValid", dRspValid[s], eDV);
         checkOutput("rndIRspData", iRspData[s], expI);
         checkOutput("rndDRspData", dRspData[s], expD);
         checkOutput("rndMemAddr", memAddr[s], expAddr);
         checkOutput("rndMemWidth", memWidth[s], expWidth);
         if (wdataKnown) checkOutput("rndMemWdata", memWdata[s], expWdata);
         if (busy && k == lat + 2) begin
            busy = 0;
         end else if (!busy && (eIReady || eDReady)) begin
            busy = 1; g = c;
            ownD = eDReady; lastD = eDReady;
            tWe = eDReady && dReqWe;
            expAddr = eDReady ? dReqAddr : iReqAddr;
            expWidth = eDReady ? dReqWidth : 3'b010;
            wdataKnown = eDReady;
            if (eDReady) expWdata = dReqWdata;
            iHs = eIReady; dHs = eDReady;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t vecs[5];
      int strobeCnt, rspCnt, iCnt, dCnt, iCyc, dCyc, stallLow, rstPulses;
      logic dGrantPrev;

      vecs[0] = '{iV: 0, dV: 0, dWe: 0, expIReady: 0, expDReady: 0, expStall: 0, expRe: 0, expWe: 0};
      vecs[1] = '{iV: 1, dV: 0, dWe: 0, expIReady: 1, expDReady: 0, expStall: 0, expRe: 1, expWe: 0};
      vecs[2] = '{iV: 0, dV: 1, dWe: 0, expIReady: 0, expDReady: 1, expStall: 0, expRe: 1, expWe: 0};
      vecs[3] = '{iV: 0, dV: 1, dWe: 1, expIReady: 0, expDReady: 1, expStall: 0, expRe: 0, expWe: 1};
      vecs[4] = '{iV: 1, dV: 1, dWe: 1, expIReady: 1, expDReady: 0, expStall: 1, expRe: 1, expWe: 0};

      for (int sel = 0; sel < 2; sel++) begin
         s = sel;
         for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);
      end

      // Single fetch, MEM_LAT=1.
      s = 0;
      applyReset();
      iReqValid = 1'b1; iReqAddr = 32'h10; memRdata = 32'h00500093;
      #1;
      checkOutput("fetchReadyT", iReady[s], 1);
      @(negedge clk); iReqValid = 1'b0; #1;
      checkOutput("fetchMemReT1", memRe[s], 1);
      checkOutput("fetchAddrT1", memAddr[s], 32'h10);
      checkOutput("fetchWidthT1", memWidth[s], 3'b010);
      @(negedge clk); #1;
      checkOutput("fetchMemReT2", memRe[s], 0);
      checkOutput("fetchRspT2", iRspValid[s], 0);
      @(negedge clk); #1;
      checkOutput("fetchRspT3", iRspValid[s], 1);
      checkOutput("fetchDataT3", iRspData[s], 32'h00500093);
      @(negedge clk); #1;
      checkOutput("fetchRspT4", iRspValid[s], 0);

      // Load then store: the store must leave both response data registers alone.
      @(negedge clk);
      runDataTxn(1'b0, 32'h80, 32'h0, 32'h11112222, 1, strobeCnt, rspCnt);
      checkOutput("loadStrobes", strobeCnt, 1);
      checkOutput("loadRsps", rspCnt, 1);
      checkOutput("loadData", dRspData[s], 32'h11112222);
      checkOutput("loadKeepsIData", iRspData[s], 32'h00500093);
      runDataTxn(1'b1, 32'h40, 32'hDEADBEEF, 32'h33334444, 1, strobeCnt, rspCnt);
      checkOutput("storeStrobes", strobeCnt, 1);
      checkOutput("storeRsps", rspCnt, 1);
      checkOutput("storeKeepsDData", dRspData[s], 32'h11112222);
      checkOutput("storeKeepsIData", iRspData[s], 32'h00500093);

      // Fetch and load together right after reset.
      applyReset();
      iReqValid = 1'b1; iReqAddr = 32'h100;
      dReqValid = 1'b1; dReqWe = 1'b0; dReqAddr = 32'h200; memRdata = 32'h0000ABCD;
      #1;
      checkOutput("bothFetchFirst", iReady[s], 1);
      checkOutput("bothLoadWaits", dReady[s], 0);
      iCnt = 0; dCnt = 0; iCyc = -1; dCyc = -1; stallLow = 0; dGrantPrev = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) iReqAddr = 32'h104;
         if (dGrantPrev) dReqValid = 1'b0;
         #1;
         dGrantPrev = dReady[s];
         if (iRspValid[s]) begin iCnt++; iCyc = k; end
         if (dRspValid[s]) begin dCnt++; dCyc = k; end
         if ((dCnt == 0 || dRspValid[s]) && !stall[s]) stallLow++;
      end
      checkOutput("bothFetchRsps", iCnt, 1);
      checkOutput("bothLoadRsps", dCnt, 1);
      checkOutput("bothOrder", (iCyc > 0) && (dCyc > iCyc), 1);
      checkOutput("bothStallHeld", stallLow, 0);
      checkOutput("bothLoadData", dRspData[s], 32'h0000ABCD);

      // MEM_LAT=4 load timing with a second load held pending.
      s = 1;
      applyReset();
      dReqValid = 1'b1; dReqWe = 1'b0; dReqAddr = 32'h300; memRdata = 32'hA0000000;
      #1;
      checkOutput("lat4Grant", dReady[s], 1);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         dReqAddr = 32'h304;
         memRdata = 32'hA0000000 + 32'(k);
         #1;
         checkOutput("lat4Ready", dReady[s], k == 7);
         checkOutput("lat4RspValid", dRspValid[s], k == 6);
         if (k == 6) checkOutput("lat4RspData", dRspData[s], 32'hA0000005);
      end

      // Reset in WAIT aborts the load; a fresh load afterwards completes.
      applyReset();
      dReqValid = 1'b1; dReqWe = 1'b0; dReqAddr = 32'h400; memRdata = 32'hFFFF0000;
      #1;
      checkOutput("abortGrant", dReady[s], 1);
      @(negedge clk); dReqValid = 1'b0; #1;
      checkOutput("abortAccessRe", memRe[s], 1);
      @(negedge clk);
      @(negedge clk); #1;
      rst = 1'b1; #1;
      checkOutput("abortMemRe", memRe[s], 0);
      checkOutput("abortMemWe", memWe[s], 0);
      checkOutput("abortRspValid", dRspValid[s], 0);
      checkOutput("abortIdle", stall[s], 0);
      rstPulses = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (k == 1) rst = 1'b0;
         #1;
         if (dRspValid[s] || iRspValid[s]) rstPulses++;
      end
      checkOutput("abortNoPulse", rstPulses, 0);
      runDataTxn(1'b0, 32'h404, 32'h0, 32'h12345678, 4, strobeCnt, rspCnt);
      checkOutput("afterAbortStrobes", strobeCnt, 1);
      checkOutput("afterAbortRsps", rspCnt, 1);
      checkOutput("afterAbortData", dRspData[s], 32'h12345678);

      s = 0;
      runRandom(1, 400);
      s = 1;
      runRandom(4, 400);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
